// File: rtl/frame_bank_arbiter.sv
// Single-port frame memory arbiter: display reads take priority over capture writes,
// with two-bank double buffering swapped only at a display frame boundary.
module frame_bank_arbiter #(
    parameter int unsigned FRAME_PIXELS = 307200,
    parameter int unsigned ADDR_W       = 19,
    parameter int unsigned DATA_W       = 24
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rd_req,
    input  logic              rd_frame_start,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_sof,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rd_bank,
    output logic              wr_bank,
    output logic              frame_drop
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
    logic [ADDR_W-1:0] wr_beat_addr;
    logic              wr_fire;
    logic              wr_write;
    logic              drop_nxt;
    logic              swap;
    logic              rd_req_d1;

    // Bank FSM: next state, write address and memory write decision
    always_comb begin
        state_nxt    = state;
        wr_addr_nxt  = wr_addr;
        wr_write     = 1'b0;
        drop_nxt     = 1'b0;
        swap         = 1'b0;
        wr_ready     = !rd_req && (state != DONE);
        wr_fire      = wr_valid && wr_ready;
        wr_beat_addr = wr_sof ? '0 : wr_addr;
        case (state)
            IDLE: begin
                if (wr_fire && wr_sof) begin
                    wr_write    = 1'b1;
                    wr_addr_nxt = ADDR_W'(1);
                    state_nxt   = FILL;
                end
            end
            FILL: begin
                if (wr_fire) begin
                    wr_write = 1'b1;
                    if (wr_sof) begin
                        wr_addr_nxt = ADDR_W'(1);
                        drop_nxt    = 1'b1;
                    end else if (wr_addr == LAST_PIX) begin
                        wr_addr_nxt = '0;
                        state_nxt   = DONE;
                    end else begin
                        wr_addr_nxt = wr_addr + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                if (rd_frame_start) begin
                    swap      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = rd_req || wr_write;
        mem_we    = wr_write;
        mem_addr  = rd_req ? {rd_bank, rd_addr} : {wr_bank, wr_beat_addr};
        mem_wdata = wr_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            wr_addr    <= '0;
            frame_drop <= 1'b0;
            rd_bank    <= 1'b0;
            wr_bank    <= 1'b1;
        end else begin
            state      <= state_nxt;
            wr_addr    <= wr_addr_nxt;
            frame_drop <= drop_nxt;
            if (swap) begin
                rd_bank <= wr_bank;
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Frame start wins over the increment; a same-cycle read still used the old address
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_addr <= '0;
        end else if (rd_frame_start) begin
            rd_addr <= '0;
        end else if (rd_req) begin
            rd_addr <= (rd_addr == LAST_PIX) ? '0 : rd_addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_req_d1 <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_req_d1 <= rd_req;
            rd_valid  <= rd_req_d1;
            if (rd_req_d1) begin
                rd_data <= mem_rdata;
            end
        end
    end

endmodule
